// File: rtl/kvz_pio_edge_irq_if.sv
// rtl/kvz_pio_edge_irq_if.sv - Avalon-MM register bus bundle for the PIO edge interrupt block
interface kvz_pio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/kvz_pio_edge_irq.sv
// rtl/kvz_pio_edge_irq.sv - PIO input block with edge capture, interrupt mask and optional event counter (KVZ_PIO_EVENT_COUNT_EN)
module kvz_pio_edge_irq #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    kvz_pio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RISE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_CAP   = 3'd3;
    localparam logic [2:0] ADDR_FALL  = 3'd4;
    localparam logic [2:0] ADDR_COUNT = 3'd5;

    // Arm window covers the synchroniser fill plus the prev_q stage, so a
    // level already present at reset release never looks like an edge.
    localparam int                ARM_W    = 3;
    localparam logic [ARM_W-1:0]  ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q;
    logic [WIDTH-1:0]                  sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
    logic [ARM_W-1:0]                  arm_q, arm_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic [31:0]                       evt_cnt_rd;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic             armed;
    logic             any_edge;
    logic             unused_wdata;

    assign sync_q       = sync_chain_q[SYNC_STAGES-1];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    assign armed    = (arm_q == '0);
    assign rise     = sync_q & ~prev_q & rise_en_q;
    assign fall     = ~sync_q & prev_q & fall_en_q;
    assign edge_det = armed ? (rise | fall) : '0;
    assign any_edge = |edge_det;

    // Synchroniser chain, one-cycle history and arm countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain_q <= '0;
            prev_q       <= '0;
            arm_q        <= ARM_LOAD;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], in_port};
            prev_q       <= sync_q;
            arm_q        <= arm_d;
        end
    end

    // Arm counter stops at zero once the input pipeline holds real history.
    always_comb begin
        arm_d = arm_q;
        if (arm_q != '0) begin
            arm_d = arm_q - 1'b1;
        end
    end

    // Register writes and capture update; a new edge wins over a same-cycle clear.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_RISE: rise_en_d  = wdata;
                ADDR_MASK: irq_mask_d = wdata;
                ADDR_FALL: fall_en_d  = wdata;
                ADDR_CAP:  edge_cap_d = edge_cap_q & ~wdata;
                default:   ;
            endcase
        end
        edge_cap_d = edge_cap_d | edge_det;
    end

    // Control and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

`ifdef KVZ_PIO_EVENT_COUNT_EN
    logic [15:0] evt_cnt_q, evt_cnt_d;

    // Saturating count of cycles with at least one edge; a write restarts it.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (wr_en && (bus.address == ADDR_COUNT)) begin
            evt_cnt_d = any_edge ? 16'd1 : 16'd0;
        end else if (any_edge && (evt_cnt_q != 16'hFFFF)) begin
            evt_cnt_d = evt_cnt_q + 16'd1;
        end
    end

    // Event counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt_rd = {16'd0, evt_cnt_q};
`else
    logic unused_any_edge;
    assign unused_any_edge = any_edge;
    assign evt_cnt_rd      = '0;
`endif

    // Read mux on the current address; chipselect intentionally not involved.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:  readdata_d[WIDTH-1:0] = sync_q;
            ADDR_RISE:  readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_MASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_CAP:   readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_FALL:  readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_COUNT: readdata_d            = evt_cnt_rd;
            default:    readdata_d            = '0;
        endcase
    end

    // Registered read data, one cycle behind the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/kvz_pio_edge_irq.md
KVZ_PIO_EDGE_IRQ -- requirements
Module: kvz_pio_edge_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 2: channel count, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, 2..4.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  3  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-009 SHALL have port in_port  input  WIDTH  asynchronous input channels.
REQ-010 SHALL have port readdata  output  32  registered read data; bits above WIDTH-1 read 0.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain; the last stage is sync_q. A register prev_q SHALL hold sync_q delayed by one cycle.
REQ-013 SHALL compute rise = sync_q & ~prev_q & RISE_EN and fall = ~sync_q & prev_q & FALL_EN, per bit; edge = rise | fall.
REQ-014 SHALL implement this register map: 0 DATA (RO, sync_q); 1 RISE_EN (RW); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (RW1C); 4 FALL_EN (RW); 5 EVENT_COUNT (see Configuration); 6-7 reserved, read 0, writes ignored.
REQ-015 SHALL treat a write as chipselect=1 and write_n=0 in the same cycle; the register updates on that clock edge.
REQ-016 SHALL register readdata every cycle from the mux of the current address, so data appears one cycle after the address is presented; chipselect does not gate readdata.
REQ-017 SHALL set EDGE_CAPTURE[i] on the clock edge where edge[i]=1; the bit stays set until cleared.
REQ-018 SHALL clear EDGE_CAPTURE[i] only when writedata[i]=1 in a write to address 3; bits written 0 stay unchanged.
REQ-019 SHALL give set priority: if edge[i] and a clear of bit i occur in the same cycle, bit i ends up 1.
REQ-020 SHALL drive irq = OR over i of (EDGE_CAPTURE[i] & IRQ_MASK[i]); irq is combinational from registers, with no extra latency.
REQ-021 SHALL set EDGE_CAPTURE[i] on the (SYNC_STAGES+1)th rising clk edge after the first edge that samples an in_port transition.
REQ-022 SHALL detect an in_port pulse only if it is held for at least one full clk period; shorter pulses may be lost.
REQ-023 SHALL hold an arm counter that suppresses edge for SYNC_STAGES+1 cycles after reset deasserts, so an input already high at reset release creates no capture.
REQ-024 SHALL keep DATA reads live during the arm window.
REQ-025 SHALL detect no edges when RISE_EN=FALL_EN=0; a bit with both enables set captures on either edge.

Reset
REQ-026 SHALL, while reset=1 at a clk edge, clear to 0: sync chain, prev_q, RISE_EN, FALL_EN, IRQ_MASK, EDGE_CAPTURE, EVENT_COUNT and readdata; irq then reads 0.
REQ-027 SHALL reload the arm counter on reset; reset asserted mid-operation discards all pending captures and register writes of that cycle.

Configuration
REQ-028 SHALL, with macro KVZ_PIO_EVENT_COUNT_EN defined, implement a 16-bit EVENT_COUNT at address 5.
REQ-029 SHALL, when enabled, increment EVENT_COUNT by 1 in each cycle where any bit of edge is 1, regardless of the number of bits.
REQ-030 SHALL saturate EVENT_COUNT at 0xFFFF.
REQ-031 SHALL clear EVENT_COUNT on any write to address 5; if an event occurs in the same cycle, the count becomes 1.
REQ-032 SHALL, without the macro, synthesise no counter; address 5 then reads 0 and ignores writes.

Verification
REQ-033 WIDTH=2, SYNC_STAGES=2, RISE_EN=3, IRQ_MASK=1; in_port 00->01 -> EDGE_CAPTURE=01 on the 3rd edge after sampling; irq=1; a read of address 3 returns 0x1.
REQ-034 EDGE_CAPTURE=11; write 0x1 to address 3 -> EDGE_CAPTURE=10; with IRQ_MASK=1, irq falls to 0 the cycle after the write.
REQ-035 FALL_EN=2, RISE_EN=0; in_port 10->00 -> EDGE_CAPTURE[1]=1; in_port 00->10 -> no capture.
REQ-036 in_port=11 held through reset release, RISE_EN=3 -> EDGE_CAPTURE stays 0, and address 0 reads 0x3 within SYNC_STAGES+1 cycles.
REQ-037 A rising edge on bit 0 lands in the same cycle as a write of 0x1 to address 3 -> EDGE_CAPTURE[0]=1.
REQ-038 With KVZ_PIO_EVENT_COUNT_EN defined: preload the count to 0xFFFE via 0xFFFE edges, apply 3 more edges -> count 0xFFFF; write to address 5 with a simultaneous edge -> count 1.
